// File: rtl/c_align_pkg.sv
// c_align_pkg: shared opcodes, RVC field enums and queue entry type for the fetch aligner
package c_align_pkg;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  typedef enum logic [1:0] {Q0 = 2'b00, Q1 = 2'b01, Q2 = 2'b10, Q3 = 2'b11} quad_e;
  typedef enum logic [2:0] {
    F3_000 = 3'b000, F3_001 = 3'b001, F3_010 = 3'b010, F3_011 = 3'b011,
    F3_100 = 3'b100, F3_101 = 3'b101, F3_110 = 3'b110, F3_111 = 3'b111
  } c_f3_e;
  typedef struct packed {
    logic        err;
    logic [15:0] hw;
  } q_entry_t;
endpackage

// File: rtl/c_align_expand_c_expand.sv
// c_expand: combinational RV32C to RV32I expander with illegal-encoding detection
module c_expand
  import c_align_pkg::*;
(
  input  logic [15:0] c,
  output logic [31:0] inst,
  output logic        illegal
);
  logic [31:0] x;
  logic        ill;
  logic [4:0]  rd, rs2, rdp, rs1p;
  logic [11:0] imm6_sx, lw_off, lwsp_off, swsp_off, a16_imm;
  logic [9:0]  a4_imm;
  logic [20:0] j_off;
  logic [12:0] b_off;
  logic [2:0]  alu_f3;
  assign rd       = c[11:7];
  assign rs2      = c[6:2];
  assign rdp      = {2'b01, c[4:2]};
  assign rs1p     = {2'b01, c[9:7]};
  assign imm6_sx  = {{6{c[12]}}, c[12], c[6:2]};
  assign a4_imm   = {c[10:7], c[12:11], c[5], c[6], 2'b00};
  assign lw_off   = {5'b0, c[5], c[12:10], c[6], 2'b00};
  assign lwsp_off = {4'b0, c[3:2], c[12], c[6:4], 2'b00};
  assign swsp_off = {4'b0, c[8:7], c[12:9], 2'b00};
  assign a16_imm  = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0};
  assign j_off    = {{10{c[12]}}, c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
  assign b_off    = {{5{c[12]}}, c[6:5], c[2], c[11:10], c[4:3], 1'b0};
  assign alu_f3   = c[6:5] == 2'b00 ? 3'b000 : {1'b1, c[6], c[6] & c[5]};
  // decode by quadrant and funct3; ill flags reserved or illegal encodings
  always_comb begin
    x   = '0;
    ill = 1'b0;
    case (quad_e'(c[1:0]))
      Q0: case (c_f3_e'(c[15:13]))
        F3_000: begin
          x   = {2'b0, a4_imm, 5'd2, 3'b000, rdp, OPC_OP_IMM};
          ill = a4_imm == '0;
        end
        F3_010: x = {lw_off, rs1p, 3'b010, rdp, OPC_LOAD};
        F3_110: x = {lw_off[11:5], rdp, rs1p, 3'b010, lw_off[4:0], OPC_STORE};
        default: ill = 1'b1;
      endcase
      Q1: case (c_f3_e'(c[15:13]))
        F3_000: x = {imm6_sx, rd, 3'b000, rd, OPC_OP_IMM};
        F3_001: x = {j_off[20], j_off[10:1], j_off[11], j_off[19:12], 5'd1, OPC_JAL};
        F3_010: x = {imm6_sx, 5'd0, 3'b000, rd, OPC_OP_IMM};
        F3_011: begin
          x   = rd == 5'd2 ? {a16_imm, 5'd2, 3'b000, 5'd2, OPC_OP_IMM}
                           : {{14{c[12]}}, c[12], c[6:2], rd, OPC_LUI};
          ill = {c[12], c[6:2]} == '0;
        end
        F3_100: begin
          x   = c[11:10] == 2'b00 ? {7'b0, c[6:2], rs1p, 3'b101, rs1p, OPC_OP_IMM} :
                c[11:10] == 2'b01 ? {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, OPC_OP_IMM} :
                c[11:10] == 2'b10 ? {imm6_sx, rs1p, 3'b111, rs1p, OPC_OP_IMM} :
                                    {1'b0, c[6:5] == 2'b00, 5'b0, rdp, rs1p, alu_f3, rs1p, OPC_OP};
          ill = c[12] && c[11:10] != 2'b10;
        end
        F3_101: x = {j_off[20], j_off[10:1], j_off[11], j_off[19:12], 5'd0, OPC_JAL};
        F3_110: x = {b_off[12], b_off[10:5], 5'd0, rs1p, 3'b000, b_off[4:1], b_off[11], OPC_BRANCH};
        default: x = {b_off[12], b_off[10:5], 5'd0, rs1p, 3'b001, b_off[4:1], b_off[11], OPC_BRANCH};
      endcase
      Q2: case (c_f3_e'(c[15:13]))
        F3_000: begin
          x   = {7'b0, c[6:2], rd, 3'b001, rd, OPC_OP_IMM};
          ill = c[12];
        end
        F3_010: begin
          x   = {lwsp_off, 5'd2, 3'b010, rd, OPC_LOAD};
          ill = rd == '0;
        end
        F3_100: begin
          x   = !c[12] ? (rs2 == '0 ? {12'b0, rd, 3'b000, 5'd0, OPC_JALR}
                                    : {7'b0, rs2, 5'd0, 3'b000, rd, OPC_OP}) :
                rs2 != '0 ? {7'b0, rs2, rd, 3'b000, rd, OPC_OP} :
                rd == '0  ? {12'd1, 13'b0, OPC_SYSTEM} :
                            {12'b0, rd, 3'b000, 5'd1, OPC_JALR};
          ill = !c[12] && rs2 == '0 && rd == '0;
        end
        F3_110: x = {swsp_off[11:5], rs2, 5'd2, 3'b010, swsp_off[4:0], OPC_STORE};
        default: ill = 1'b1;
      endcase
      default: ill = 1'b1;
    endcase
  end
  assign inst    = ill ? {16'h0, c} : x;
  assign illegal = ill;
endmodule

// File: rtl/c_align_expand.sv
// c_align_expand: halfword fetch queue that aligns, expands and tags one instruction per cycle
module c_align_expand
  import c_align_pkg::*;
#(
  parameter int          FETCH_W  = 32,
  parameter int          DEPTH_HW = 8,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic [31:0]               flush_pc_i,
  input  logic                      fetch_valid_i,
  output logic                      fetch_ready_o,
  input  logic [FETCH_W-1:0]        fetch_data_i,
  input  logic                      fetch_err_i,
  output logic                      inst_valid_o,
  input  logic                      inst_ready_i,
  output logic [31:0]               inst_o,
  output logic [31:0]               inst_pc_o,
  output logic                      inst_comp_o,
  output logic                      inst_illegal_o,
  output logic                      inst_err_o,
  output logic [$clog2(DEPTH_HW):0] occupancy_o
);
  localparam int NHW = FETCH_W / 16;
  localparam int PW  = $clog2(DEPTH_HW);
  localparam int CW  = PW + 1;
  localparam int SKW = $clog2(FETCH_W / 8) - 1;
  q_entry_t       q [DEPTH_HW];
  q_entry_t       h0, h1;
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  count, push_n, pop_n;
  logic [31:0]    pc, exp_inst;
  logic [SKW-1:0] skip;
  logic           armed, push, pop, is32, valid, exp_ill;
  assign h0            = q[rd_ptr];
  assign h1            = q[rd_ptr + PW'(1)];
  assign is32          = h0.hw[1:0] == 2'b11 && !h0.err;
  assign valid         = count >= (is32 ? CW'(2) : CW'(1));
  assign fetch_ready_o = CW'(DEPTH_HW) - count >= CW'(NHW);
  assign skip          = armed ? pc[SKW:1] : '0;
  assign push          = fetch_valid_i && fetch_ready_o && !flush_i && !rst;
  assign pop           = valid && inst_ready_i && !flush_i;
  assign push_n        = push ? CW'(NHW) - CW'(skip) : '0;
  assign pop_n         = pop ? (is32 ? CW'(2) : CW'(1)) : '0;
  c_expand u_expand (
    .c       (h0.hw),
    .inst    (exp_inst),
    .illegal (exp_ill)
  );
  // write the accepted halfwords, dropping the ones below the entry PC after a redirect
  always_ff @(posedge clk)
    for (int i = 0; i < NHW; i++)
      if (push && SKW'(i) >= skip)
        q[wr_ptr + PW'(i) - PW'(skip)] <= {fetch_err_i, fetch_data_i[16*i +: 16]};
  // pointers, occupancy and PC; reset and flush both restart the stream
  always_ff @(posedge clk)
    if (rst || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      armed  <= 1'b1;
      pc     <= rst ? RESET_PC : flush_pc_i & ~32'd1;
    end else begin
      wr_ptr <= wr_ptr + push_n[PW-1:0];
      rd_ptr <= rd_ptr + pop_n[PW-1:0];
      count  <= count + push_n - pop_n;
      if (push) armed <= 1'b0;
      if (pop) pc <= pc + (is32 ? 32'd4 : 32'd2);
    end
  assign inst_valid_o   = valid;
  assign inst_o         = is32 ? {h1.hw, h0.hw} : exp_inst;
  assign inst_pc_o      = pc;
  assign inst_comp_o    = !is32;
  assign inst_illegal_o = !is32 && exp_ill;
  assign inst_err_o     = h0.err || (is32 && h1.err);
  assign occupancy_o    = count;
endmodule

// File: tb/tb_c_align_expand.sv
// tb_c_align_expand: directed and randomized check of the aligner against a halfword-queue model
module tb_c_align_expand;
  localparam int DEPTH = 8;
  localparam int NHW   = 2;
  localparam int NT    = 17;
  logic        clk = 0, rst = 1, flush_i = 0, fetch_valid_i = 0, fetch_err_i = 0, inst_ready_i = 0;
  logic [31:0] flush_pc_i = 0, fetch_data_i = 0;
  logic        fetch_ready_o, inst_valid_o, inst_comp_o, inst_illegal_o, inst_err_o;
  logic [31:0] inst_o, inst_pc_o;
  logic [3:0]  occupancy_o;
  int          n_cmp = 0, n_bad = 0;
  typedef struct packed {logic err; logic [15:0] hw;} hw_t;
  hw_t         mq[$];
  logic [31:0] mpc;
  bit          marmed;
  logic [15:0] src[$];
  logic [15:0] t_hw [NT] = '{16'h4501, 16'h0001, 16'h6141, 16'h0000, 16'h8082, 16'h852E,
                             16'h9002, 16'h4082, 16'h4002, 16'h1141, 16'h1002, 16'h8C01,
                             16'h9C01, 16'h2000, 16'h4108, 16'hA001, 16'hC101};
  logic [31:0] t_ex [NT] = '{32'h0000_0513, 32'h0000_0013, 32'h0101_0113, 32'h0000_0000,
                             32'h0000_8067, 32'h00B0_0533, 32'h0010_0073, 32'h0001_2083,
                             32'h0000_4002, 32'hFF01_0113, 32'h0000_1002, 32'h4084_0433,
                             32'h0000_9C01, 32'h0000_2000, 32'h0005_2503, 32'h0000_006F,
                             32'h0005_0063};
  bit          t_il [NT] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0};

  c_align_expand dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .flush_pc_i     (flush_pc_i),
    .fetch_valid_i  (fetch_valid_i),
    .fetch_ready_o  (fetch_ready_o),
    .fetch_data_i   (fetch_data_i),
    .fetch_err_i    (fetch_err_i),
    .inst_valid_o   (inst_valid_o),
    .inst_ready_i   (inst_ready_i),
    .inst_o         (inst_o),
    .inst_pc_o      (inst_pc_o),
    .inst_comp_o    (inst_comp_o),
    .inst_illegal_o (inst_illegal_o),
    .inst_err_o     (inst_err_o),
    .occupancy_o    (occupancy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input logic [15:0] hw, output bit found, output logic [31:0] ex, output bit il);
    found = 0;
    ex = '0;
    il = 0;
    for (int i = 0; i < NT; i++)
      if (t_hw[i] == hw) begin
        found = 1;
        ex = t_ex[i];
        il = t_il[i];
      end
  endtask

  function automatic bit m_is32();
    return mq.size() > 0 && mq[0].hw[1:0] == 2'b11 && !mq[0].err;
  endfunction

  function automatic bit m_valid();
    return mq.size() >= (m_is32() ? 2 : 1);
  endfunction

  function automatic bit m_ready();
    return (DEPTH - mq.size()) >= NHW;
  endfunction

  task automatic check_outputs();
    bit          m32, found, il;
    logic [31:0] ex;
    m32 = m_is32();
    chk("occupancy", 32'(occupancy_o), 32'(mq.size()));
    chk("fetch_ready", 32'(fetch_ready_o), 32'(m_ready()));
    chk("inst_valid", 32'(inst_valid_o), 32'(m_valid()));
    chk("inst_pc", inst_pc_o, mpc);
    if (m_valid()) begin
      chk("inst_comp", 32'(inst_comp_o), 32'(!m32));
      chk("inst_err", 32'(inst_err_o), 32'(m32 ? (mq[0].err | mq[1].err) : mq[0].err));
      if (m32) begin
        chk("inst32", inst_o, {mq[1].hw, mq[0].hw});
        chk("illegal32", 32'(inst_illegal_o), 32'd0);
      end else begin
        lookup(mq[0].hw, found, ex, il);
        if (found) begin
          chk("inst16", inst_o, ex);
          chk("illegal16", 32'(inst_illegal_o), 32'(il));
        end
      end
    end
  endtask

  task automatic cycle(input bit fv, input logic [31:0] fd, input bit fe, input bit rdy,
                       input bit fl = 0, input logic [31:0] fpc = 0);
    bit m32, mv, acc;
    int skip;
    check_outputs();
    fetch_valid_i = fv;
    fetch_data_i  = fd;
    fetch_err_i   = fe;
    inst_ready_i  = rdy;
    flush_i       = fl;
    flush_pc_i    = fpc;
    if (fl) begin
      mq.delete();
      mpc = {fpc[31:1], 1'b0};
      marmed = 1;
    end else begin
      m32  = m_is32();
      mv   = m_valid();
      acc  = fv && m_ready();
      skip = marmed ? int'(mpc[1]) : 0;
      if (mv && rdy) begin
        repeat (m32 ? 2 : 1) void'(mq.pop_front());
        mpc += m32 ? 32'd4 : 32'd2;
      end
      if (acc) begin
        for (int i = skip; i < NHW; i++) mq.push_back({fe, fd[16*i +: 16]});
        marmed = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] cword();
    return {t_hw[$urandom_range(0, NT - 1)], t_hw[$urandom_range(0, NT - 1)]};
  endfunction

  task automatic gen_inst();
    logic [31:0] w;
    w = $urandom();
    if ($urandom_range(0, 9) < 7) src.push_back(t_hw[$urandom_range(0, NT - 1)]);
    else begin
      src.push_back({w[15:2], 2'b11});
      src.push_back(w[31:16]);
    end
  endtask

  initial begin
    bit          fv, fe, rdy, fl, acc;
    logic [31:0] fpc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    mpc = 32'h8000_0000;
    marmed = 1;
    chk("rst_occupancy", 32'(occupancy_o), 32'd0);
    chk("rst_ready", 32'(fetch_ready_o), 32'd1);
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_pc", inst_pc_o, 32'h8000_0000);
    // compressed pair
    cycle(1, 32'h0001_4501, 0, 0);
    chk("pair0_inst", inst_o, 32'h0000_0513);
    chk("pair0_pc", inst_pc_o, 32'h8000_0000);
    chk("pair0_comp", 32'(inst_comp_o), 32'd1);
    cycle(0, 0, 0, 1);
    chk("pair1_inst", inst_o, 32'h0000_0013);
    chk("pair1_pc", inst_pc_o, 32'h8000_0002);
    cycle(0, 0, 0, 1);
    // straddling 32-bit instruction
    cycle(0, 0, 0, 0, 1, 32'h8000_0000);
    cycle(1, 32'h0513_4501, 0, 1);
    chk("str0_inst", inst_o, 32'h0000_0513);
    cycle(0, 0, 0, 1);
    chk("str_wait_valid", 32'(inst_valid_o), 32'd0);
    cycle(1, 32'h4501_0000, 0, 1);
    chk("str1_inst", inst_o, 32'h0000_0513);
    chk("str1_pc", inst_pc_o, 32'h8000_0002);
    chk("str1_comp", 32'(inst_comp_o), 32'd0);
    cycle(0, 0, 0, 1);
    chk("str2_pc", inst_pc_o, 32'h8000_0006);
    cycle(0, 0, 0, 1);
    // redirect to a halfword-aligned PC skips the low halfword
    cycle(0, 0, 0, 0, 1, 32'h8000_0103);
    cycle(1, 32'h4501_FFFF, 0, 0);
    chk("mis_occupancy", 32'(occupancy_o), 32'd1);
    chk("mis_inst", inst_o, 32'h0000_0513);
    chk("mis_pc", inst_pc_o, 32'h8000_0102);
    cycle(0, 0, 0, 1);
    // backpressure to full, then drain while refilling across the wrap
    cycle(0, 0, 0, 0, 1, 32'h8000_0000);
    repeat (4) cycle(1, cword(), 0, 0);
    chk("full_occupancy", 32'(occupancy_o), 32'd8);
    chk("full_ready", 32'(fetch_ready_o), 32'd0);
    cycle(1, cword(), 0, 0);
    chk("full_reject", 32'(occupancy_o), 32'd8);
    repeat (24) cycle(1, cword(), 0, 1);
    repeat (12) cycle(0, 0, 0, 1);
    chk("drain_empty", 32'(occupancy_o), 32'd0);
    // illegal zero halfword and ADDI16SP
    cycle(0, 0, 0, 0, 1, 32'h8000_0000);
    cycle(1, 32'h6141_0000, 0, 0);
    chk("zero_illegal", 32'(inst_illegal_o), 32'd1);
    chk("zero_inst", inst_o, 32'h0);
    cycle(0, 0, 0, 1);
    chk("a16sp_inst", inst_o, 32'h0101_0113);
    chk("a16sp_illegal", 32'(inst_illegal_o), 32'd0);
    cycle(0, 0, 0, 1);
    // flush colliding with push and pop, then an errored fetch
    cycle(1, 32'h4501_4501, 0, 0);
    cycle(1, 32'h0001_0001, 0, 1, 1, 32'h8000_0200);
    chk("coll_valid", 32'(inst_valid_o), 32'd0);
    chk("coll_occupancy", 32'(occupancy_o), 32'd0);
    cycle(1, 32'h4501_4501, 1, 0);
    chk("err_flag", 32'(inst_err_o), 32'd1);
    chk("err_pc", inst_pc_o, 32'h8000_0200);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    // randomized mixed stream with occasional redirects and faults
    for (int n = 0; n < 600; n++) begin
      while (src.size() < 2) gen_inst();
      fv  = $urandom_range(0, 3) != 0;
      fe  = $urandom_range(0, 19) == 0;
      rdy = $urandom_range(0, 9) < 7;
      fl  = $urandom_range(0, 49) == 0;
      fpc = $urandom();
      acc = fv && !fl && m_ready();
      cycle(fv, {src[1], src[0]}, fe, rdy, fl, fpc);
      if (fl) begin
        src.delete();
        if (fpc[1]) src.push_back(16'hFFFF);
      end else if (acc) begin
        void'(src.pop_front());
        void'(src.pop_front());
      end
    end
    repeat (12) cycle(0, 0, 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
